// File: rtl/qpsk_link_ctrl.sv
// Frame-level controller for the DQPSK modem: serialises TX frames (warm-up, preamble, sync,
// payload, tail) and hunts/deserialises RX frames from the bit-sync qualified stream.
module qpsk_link_ctrl #(
   parameter int unsigned PAYLOAD_BYTES = 8,
   parameter int unsigned WARMUP_BITS   = 16,
   parameter int unsigned PREAMBLE_BITS = 32,
   parameter logic [15:0] SYNC_WORD     = 16'hF628,
   parameter int unsigned TAIL_BITS     = 4,
   parameter int unsigned RX_TIMEOUT    = 64
) (
   input  logic       clk_data,
   input  logic       rstn,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_underrun,
   output logic       mod_rstn,
   output logic       tx_bit,
   input  logic       rx_bit,
   input  logic       rx_bit_en,
   output logic       rx_locked,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       rx_frame_done,
   output logic       rx_abort
);

   typedef enum logic [2:0] {TxIdle, TxWarm, TxPre, TxSync, TxPay, TxTail} tx_state_e;
   typedef enum logic {RxHunt, RxRecv} rx_state_e;

   localparam logic [7:0]  LastByte  = 8'(PAYLOAD_BYTES - 1);
   localparam logic [7:0]  WarmLast  = 8'(WARMUP_BITS - 1);
   localparam logic [7:0]  PreLast   = 8'(PREAMBLE_BITS - 1);
   localparam logic [7:0]  TailLast  = 8'(TAIL_BITS - 1);
   localparam logic [15:0] RxTimeout = 16'(RX_TIMEOUT);

   tx_state_e   tx_st_q, tx_st_d;
   logic [7:0]  tx_cnt_q, tx_cnt_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [7:0]  tx_idx_q, tx_idx_d;
   logic        tx_ready_q, tx_ready_d;
   logic        tx_busy_q, tx_busy_d;
   logic        mod_rstn_q, mod_rstn_d;
   logic        tx_bit_q, tx_bit_d;

   rx_state_e   rx_st_q, rx_st_d;
   logic [15:0] rx_sync_q, rx_sync_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [2:0]  rx_bitcnt_q, rx_bitcnt_d;
   logic [7:0]  rx_bytes_q, rx_bytes_d;
   logic [15:0] rx_idle_q, rx_idle_d;
   logic        rx_locked_q, rx_locked_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_done_q, rx_done_d;
   logic        rx_abort_q, rx_abort_d;

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_sh_d  = tx_sh_q;
      tx_idx_d = tx_idx_q;
      unique case (tx_st_q)
         TxIdle: begin
            if (tx_valid && tx_ready_q) begin
               tx_st_d  = TxWarm;
               tx_cnt_d = 8'd0;
               tx_sh_d  = tx_byte;
               tx_idx_d = 8'd0;
            end
         end
         TxWarm: begin
            if (tx_cnt_q == WarmLast) begin
               tx_st_d  = TxPre;
               tx_cnt_d = 8'd0;
            end else begin
               tx_cnt_d = tx_cnt_q + 8'd1;
            end
         end
         TxPre: begin
            if (tx_cnt_q == PreLast) begin
               tx_st_d  = TxSync;
               tx_cnt_d = 8'd0;
            end else begin
               tx_cnt_d = tx_cnt_q + 8'd1;
            end
         end
         TxSync: begin
            if (tx_cnt_q == 8'd15) begin
               tx_st_d  = TxPay;
               tx_cnt_d = 8'd0;
            end else begin
               tx_cnt_d = tx_cnt_q + 8'd1;
            end
         end
         TxPay: begin
            if (tx_cnt_q == 8'd7) begin
               tx_cnt_d = 8'd0;
               if (tx_idx_q == LastByte) begin
                  tx_st_d = TxTail;
               end else begin
                  // Missing byte is replaced by 0x00 so the frame keeps its length
                  tx_sh_d  = tx_valid ? tx_byte : 8'h00;
                  tx_idx_d = tx_idx_q + 8'd1;
               end
            end else begin
               tx_sh_d  = {tx_sh_q[6:0], 1'b0};
               tx_cnt_d = tx_cnt_q + 8'd1;
            end
         end
         TxTail: begin
            if (tx_cnt_q == TailLast) begin
               tx_st_d  = TxIdle;
               tx_cnt_d = 8'd0;
            end else begin
               tx_cnt_d = tx_cnt_q + 8'd1;
            end
         end
         default: tx_st_d = TxIdle;
      endcase

      // Outputs are derived from the next state so they register in step with it
      tx_ready_d = (tx_st_d == TxIdle) ||
                   ((tx_st_d == TxPay) && (tx_cnt_d == 8'd7) && (tx_idx_d != LastByte));
      tx_busy_d  = (tx_st_d != TxIdle);
      mod_rstn_d = (tx_st_d != TxIdle);
      unique case (tx_st_d)
         TxPre:   tx_bit_d = ~tx_cnt_d[0];
         TxSync:  tx_bit_d = SYNC_WORD[4'd15 - tx_cnt_d[3:0]];
         TxPay:   tx_bit_d = tx_sh_d[7];
         default: tx_bit_d = 1'b0;
      endcase
   end

   always_comb begin
      rx_st_d     = rx_st_q;
      rx_sync_d   = rx_sync_q;
      rx_sh_d     = rx_sh_q;
      rx_bitcnt_d = rx_bitcnt_q;
      rx_bytes_d  = rx_bytes_q;
      rx_idle_d   = rx_idle_q;
      rx_locked_d = rx_locked_q;
      rx_byte_d   = rx_byte_q;
      rx_valid_d  = 1'b0;
      rx_done_d   = 1'b0;
      rx_abort_d  = 1'b0;
      unique case (rx_st_q)
         RxHunt: begin
            rx_idle_d = 16'd0;
            if (rx_bit_en) begin
               rx_sync_d = {rx_sync_q[14:0], rx_bit};
               if (rx_sync_d == SYNC_WORD) begin
                  rx_st_d     = RxRecv;
                  rx_locked_d = 1'b1;
                  rx_bitcnt_d = 3'd0;
                  rx_bytes_d  = 8'd0;
                  rx_sh_d     = 8'd0;
                  rx_idle_d   = 16'd1;
               end
            end
         end
         RxRecv: begin
            if (rx_bit_en) begin
               // Idle count holds cycles elapsed since the last strobe
               rx_idle_d   = 16'd1;
               rx_sh_d     = {rx_sh_q[6:0], rx_bit};
               rx_bitcnt_d = rx_bitcnt_q + 3'd1;
               if (rx_bitcnt_q == 3'd7) begin
                  rx_byte_d  = rx_sh_d;
                  rx_valid_d = 1'b1;
                  rx_bytes_d = rx_bytes_q + 8'd1;
                  if (rx_bytes_q == LastByte) begin
                     rx_done_d   = 1'b1;
                     rx_st_d     = RxHunt;
                     rx_locked_d = 1'b0;
                     rx_sync_d   = 16'd0;
                  end
               end
            end else begin
               rx_idle_d = rx_idle_q + 16'd1;
               if (rx_idle_d == RxTimeout) begin
                  rx_abort_d  = 1'b1;
                  rx_st_d     = RxHunt;
                  rx_locked_d = 1'b0;
                  rx_sync_d   = 16'd0;
                  rx_bitcnt_d = 3'd0;
               end
            end
         end
         default: rx_st_d = RxHunt;
      endcase
   end

   always_ff @(posedge clk_data or negedge rstn) begin
      if (!rstn) begin
         tx_st_q     <= TxIdle;
         tx_cnt_q    <= 8'd0;
         tx_sh_q     <= 8'd0;
         tx_idx_q    <= 8'd0;
         tx_ready_q  <= 1'b0;
         tx_busy_q   <= 1'b0;
         mod_rstn_q  <= 1'b0;
         tx_bit_q    <= 1'b0;
         rx_st_q     <= RxHunt;
         rx_sync_q   <= 16'd0;
         rx_sh_q     <= 8'd0;
         rx_bitcnt_q <= 3'd0;
         rx_bytes_q  <= 8'd0;
         rx_idle_q   <= 16'd0;
         rx_locked_q <= 1'b0;
         rx_byte_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         rx_done_q   <= 1'b0;
         rx_abort_q  <= 1'b0;
      end else begin
         tx_st_q     <= tx_st_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_sh_q     <= tx_sh_d;
         tx_idx_q    <= tx_idx_d;
         tx_ready_q  <= tx_ready_d;
         tx_busy_q   <= tx_busy_d;
         mod_rstn_q  <= mod_rstn_d;
         tx_bit_q    <= tx_bit_d;
         rx_st_q     <= rx_st_d;
         rx_sync_q   <= rx_sync_d;
         rx_sh_q     <= rx_sh_d;
         rx_bitcnt_q <= rx_bitcnt_d;
         rx_bytes_q  <= rx_bytes_d;
         rx_idle_q   <= rx_idle_d;
         rx_locked_q <= rx_locked_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_done_q   <= rx_done_d;
         rx_abort_q  <= rx_abort_d;
      end
   end

   assign tx_ready      = tx_ready_q;
   assign tx_busy       = tx_busy_q;
   assign mod_rstn      = mod_rstn_q;
   assign tx_bit        = tx_bit_q;
   // The substitution happens in the load cycle itself, so the flag follows tx_valid directly
   assign tx_underrun   = (tx_st_q == TxPay) && tx_ready_q && !tx_valid;
   assign rx_locked     = rx_locked_q;
   assign rx_byte       = rx_byte_q;
   assign rx_byte_valid = rx_valid_q;
   assign rx_frame_done = rx_done_q;
   assign rx_abort      = rx_abort_q;

endmodule
